cia_timer_bank: RTL and testbench

CIA_TIMER_BANK -- requirements
Module: cia_timer_bank

---
 rtl/cia_timer_bank.sv | 189 ++++++++++++++++++
 tb/tb_cia_timer_bank.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cia_timer_bank.sv
// cia_timer_bank: bank of NCH 16-bit down-counting interval timers with a
// shared interrupt control register. It borrows the CIA-style register map:
// a HI/LO read-hold pair, one-shot/continuous modes, LOAD strobe, and an
// optional cascade from each channel into the next.
module cia_timer_bank #(
    parameter int unsigned NCH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk7_en,
    input  logic       aen,
    input  logic       rd,
    input  logic       wr,
    input  logic [4:0] rs,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       eclk,
    output logic       irq
);

    localparam int unsigned       CNT_W     = 16;
    localparam int unsigned       CR_W      = 8;
    localparam logic [4:0]        ICR_ADDR  = 5'h1F;
    localparam logic [CR_W-1:0]   CR_WMASK  = 8'hEF;
    localparam logic [CNT_W-1:0]  CNT_RESET = 16'hFFFF;

    // CR bit positions
    localparam int unsigned CR_START   = 0;
    localparam int unsigned CR_ONESHOT = 3;
    localparam int unsigned CR_LOAD    = 4;

    // Input-mode encodings
    localparam logic [1:0] MODE_ECLK  = 2'b00;
    localparam logic [1:0] MODE_CLK   = 2'b01;
    localparam logic [1:0] MODE_CASC  = 2'b10;

    logic [CNT_W-1:0] latch   [NCH];
    logic [CNT_W-1:0] counter [NCH];
    logic [CR_W-1:0]  cr      [NCH];
    logic [7:0]       hold    [NCH];
    logic [NCH-1:0]   hold_valid;
    logic [NCH-1:0]   flag;
    logic [NCH-1:0]   mask;
    logic [NCH-1:0]   uf_q;

    logic             rd_acc;
    logic             wr_acc;
    logic             rd_icr;
    logic             wr_icr;
    logic [NCH-1:0]   rd_lo, rd_hi, rd_cr;
    logic [NCH-1:0]   wr_lo, wr_hi, wr_cr;
    logic [NCH-1:0]   load_wr;
    logic [NCH-1:0]   count_ev;
    logic [NCH-1:0]   underflow;
    logic [NCH-1:0]   casc;
    logic             src;

    // A simultaneous rd+wr is treated as a write only.
    assign rd_acc = aen & rd & ~wr;
    assign wr_acc = aen & wr;
    assign rd_icr = rd_acc & (rs == ICR_ADDR);
    assign wr_icr = wr_acc & (rs == ICR_ADDR);

    // Cascade source for channel n is the registered underflow of n-1;
    // channel 0 falls back to eclk.
    assign casc = NCH'({uf_q, eclk});

    assign irq = |(flag & mask);

    // Per-channel register decode
    always_comb begin
        rd_lo = '0;
        rd_hi = '0;
        rd_cr = '0;
        wr_lo = '0;
        wr_hi = '0;
        wr_cr = '0;
        for (int n = 0; n < NCH; n++) begin
            rd_lo[n] = rd_acc & (rs == 5'(4 * n));
            rd_hi[n] = rd_acc & (rs == 5'(4 * n + 1));
            rd_cr[n] = rd_acc & (rs == 5'(4 * n + 2));
            wr_lo[n] = wr_acc & (rs == 5'(4 * n));
            wr_hi[n] = wr_acc & (rs == 5'(4 * n + 1));
            wr_cr[n] = wr_acc & (rs == 5'(4 * n + 2));
        end
    end

    // Count-event selection and underflow detection; LOAD suppresses underflow
    always_comb begin
        src       = 1'b0;
        load_wr   = '0;
        count_ev  = '0;
        underflow = '0;
        for (int n = 0; n < NCH; n++) begin
            case (cr[n][6:5])
                MODE_ECLK: src = eclk;
                MODE_CLK:  src = 1'b1;
                MODE_CASC: src = casc[n];
                default:   src = 1'b0;
            endcase
            load_wr[n]   = wr_cr[n] & data_in[CR_LOAD];
            count_ev[n]  = cr[n][CR_START] & src;
            underflow[n] = count_ev[n] & (counter[n] == '0) & ~load_wr[n];
        end
    end

    // Channel state, flags and mask; all updates gated by clk7_en
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                for (int n = 0; n < NCH; n++) begin
                    latch[n]   <= CNT_RESET;
                    counter[n] <= CNT_RESET;
                    cr[n]      <= '0;
                    hold[n]    <= '0;
                end
                hold_valid <= '0;
                flag       <= '0;
                mask       <= '0;
                uf_q       <= '0;
            end else begin
                for (int n = 0; n < NCH; n++) begin
                    if (wr_lo[n]) begin
                        latch[n][7:0] <= data_in;
                    end
                    if (wr_hi[n]) begin
                        latch[n][15:8] <= data_in;
                    end

                    // LOAD beats counting; HI write only loads a stopped timer
                    if (load_wr[n]) begin
                        counter[n] <= latch[n];
                    end else if (wr_hi[n] && !cr[n][CR_START]) begin
                        counter[n] <= {data_in, latch[n][7:0]};
                    end else if (underflow[n]) begin
                        counter[n] <= latch[n];
                    end else if (count_ev[n]) begin
                        counter[n] <= counter[n] - CNT_W'(1);
                    end

                    // A CR write in the same cycle wins over the one-shot stop
                    if (wr_cr[n]) begin
                        cr[n] <= data_in & CR_WMASK;
                    end else if (underflow[n] && cr[n][CR_ONESHOT]) begin
                        cr[n][CR_START] <= 1'b0;
                    end

                    if (rd_hi[n]) begin
                        hold[n]       <= counter[n][7:0];
                        hold_valid[n] <= 1'b1;
                    end else if (rd_lo[n]) begin
                        hold_valid[n] <= 1'b0;
                    end
                end

                uf_q <= underflow;
                flag <= (rd_icr ? '0 : flag) | underflow;

                if (wr_icr) begin
                    if (data_in[7]) begin
                        mask <= mask | data_in[NCH-1:0];
                    end else begin
                        mask <= mask & ~data_in[NCH-1:0];
                    end
                end
            end
        end
    end

    // Read mux: OR of per-register terms, only the selected one is non-zero
    always_comb begin
        data_out = '0;
        for (int n = 0; n < NCH; n++) begin
            if (rd_lo[n]) begin
                data_out = data_out | (hold_valid[n] ? hold[n] : counter[n][7:0]);
            end
            if (rd_hi[n]) begin
                data_out = data_out | counter[n][15:8];
            end
            if (rd_cr[n]) begin
                data_out = data_out | cr[n];
            end
        end
        if (rd_icr) begin
            data_out = data_out | {irq, 7'(flag)};
        end
    end

endmodule

// File: tb/tb_cia_timer_bank.sv
// tb_cia_timer_bank: directed register-level test of cia_timer_bank with
// hand-computed expected values for counting, one-shot, cascade, read hold,
// ICR flag/mask behaviour, LOAD override, clock enable and reset priority.
module tb_cia_timer_bank;

    logic       clk;
    logic       reset;
    logic       clk7_en;
    logic       aen;
    logic       rd;
    logic       wr;
    logic [4:0] rs;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       eclk;
    logic       irq;

    int n_checks;
    int n_fail;

    localparam logic [4:0] LO0 = 5'h00;
    localparam logic [4:0] HI0 = 5'h01;
    localparam logic [4:0] CR0 = 5'h02;
    localparam logic [4:0] RS0 = 5'h03;
    localparam logic [4:0] LO1 = 5'h04;
    localparam logic [4:0] HI1 = 5'h05;
    localparam logic [4:0] CR1 = 5'h06;
    localparam logic [4:0] ICR = 5'h1F;
    localparam logic [4:0] UNM = 5'h10;

    cia_timer_bank #(.NCH(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .clk7_en  (clk7_en),
        .aen      (aen),
        .rd       (rd),
        .wr       (wr),
        .rs       (rs),
        .data_in  (data_in),
        .data_out (data_out),
        .eclk     (eclk),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Each bus task consumes exactly one rising edge.
    task automatic wr_reg(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        aen = 1'b1; wr = 1'b1; rd = 1'b0; rs = a; data_in = d;
        @(posedge clk);
        #1;
        aen = 1'b0; wr = 1'b0; data_in = 8'h00;
    endtask

    task automatic rd_reg(input string tag, input logic [4:0] a, input logic [7:0] exp);
        @(negedge clk);
        aen = 1'b1; rd = 1'b1; wr = 1'b0; rs = a;
        #1;
        check(tag, data_out, exp);
        @(posedge clk);
        #1;
        aen = 1'b0; rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        clk7_en  = 1'b1;
        aen      = 1'b0;
        rd       = 1'b0;
        wr       = 1'b0;
        rs       = 5'h00;
        data_in  = 8'h00;
        eclk     = 1'b0;
        idle(2);
        reset = 1'b0;

        // Reset state
        #1;
        check("rst_irq", 8'(irq), 8'h00);
        check("rst_dout_idle", data_out, 8'h00);
        rd_reg("rst_cr0", CR0, 8'h00);
        rd_reg("rst_icr", ICR, 8'h00);
        rd_reg("rst_hi1", HI1, 8'hFF);
        rd_reg("rst_lo1", LO1, 8'hFF);
        rd_reg("rst_unmapped", UNM, 8'h00);

        // Continuous count in clk7_en mode, period latch+1, ICR/irq
        do_reset();
        wr_reg(LO0, 8'h03);
        wr_reg(HI0, 8'h00);
        wr_reg(RS0, 8'h5A);
        rd_reg("reserved_rd", RS0, 8'h00);
        wr_reg(ICR, 8'h81);
        wr_reg(CR0, 8'h21);
        rd_reg("cont_icr_e1", ICR, 8'h00);
        rd_reg("cont_lo_2", LO0, 8'h02);
        rd_reg("cont_lo_1", LO0, 8'h01);
        check("cont_irq_pre", 8'(irq), 8'h00);
        rd_reg("cont_lo_0", LO0, 8'h00);
        check("cont_irq_set", 8'(irq), 8'h01);
        rd_reg("cont_icr_uf1", ICR, 8'h81);
        check("cont_irq_clr", 8'(irq), 8'h00);
        rd_reg("cont_icr_e6", ICR, 8'h00);
        rd_reg("cont_icr_e7", ICR, 8'h00);
        rd_reg("icr_coincident", ICR, 8'h00);
        check("icr_flag_kept_irq", 8'(irq), 8'h01);
        rd_reg("icr_flag_kept", ICR, 8'h81);
        rd_reg("cont_icr_e10", ICR, 8'h00);

        // One-shot: underflow after 2 events, START cleared, counter frozen
        do_reset();
        wr_reg(LO0, 8'h01);
        wr_reg(HI0, 8'h00);
        wr_reg(CR0, 8'h29);
        idle(2);
        rd_reg("os_cr", CR0, 8'h28);
        wr_reg(ICR, 8'h81);
        check("mask_set_irq", 8'(irq), 8'h01);
        wr_reg(ICR, 8'h01);
        check("mask_clr_irq", 8'(irq), 8'h00);
        rd_reg("os_icr", ICR, 8'h01);
        idle(3);
        rd_reg("os_lo", LO0, 8'h01);
        rd_reg("os_hi", HI0, 8'h00);
        rd_reg("os_icr_once", ICR, 8'h00);

        // Cascade: ch1 counts registered ch0 underflows
        do_reset();
        wr_reg(LO0, 8'h00);
        wr_reg(HI0, 8'h00);
        wr_reg(LO1, 8'h02);
        wr_reg(HI1, 8'h00);
        wr_reg(CR1, 8'h41);
        wr_reg(CR0, 8'h21);
        rd_reg("casc_e1", ICR, 8'h00);
        rd_reg("casc_e2", ICR, 8'h01);
        rd_reg("casc_e3", ICR, 8'h01);
        rd_reg("casc_e4", ICR, 8'h01);
        rd_reg("casc_e5", ICR, 8'h03);
        rd_reg("casc_e6", ICR, 8'h01);
        rd_reg("casc_e7", ICR, 8'h01);
        rd_reg("casc_e8", ICR, 8'h03);

        // HI read holds LO byte until the next LO read
        do_reset();
        wr_reg(LO0, 8'hFF);
        wr_reg(HI0, 8'h01);
        wr_reg(CR0, 8'h21);
        rd_reg("hold_hi", HI0, 8'h01);
        rd_reg("hold_lo", LO0, 8'hFF);
        rd_reg("hold_live", LO0, 8'hFD);

        // LOAD coinciding with an underflow event: reload, no flag
        do_reset();
        wr_reg(LO0, 8'h02);
        wr_reg(HI0, 8'h00);
        wr_reg(CR0, 8'h21);
        idle(2);
        wr_reg(CR0, 8'h31);
        rd_reg("load_noflag", ICR, 8'h00);
        rd_reg("load_cnt", LO0, 8'h01);
        rd_reg("load_cr_rd", CR0, 8'h21);
        rd_reg("load_next_uf", ICR, 8'h01);

        // clk7_en low freezes counting
        do_reset();
        wr_reg(LO0, 8'h03);
        wr_reg(HI0, 8'h00);
        wr_reg(CR0, 8'h21);
        @(negedge clk);
        clk7_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        clk7_en = 1'b1;
        rd_reg("clken_frozen", LO0, 8'h03);

        // eclk mode and reset priority over a coincident underflow
        do_reset();
        wr_reg(LO0, 8'h01);
        wr_reg(HI0, 8'h00);
        wr_reg(CR0, 8'h01);
        idle(2);
        rd_reg("eclk_idle", LO0, 8'h01);
        @(negedge clk);
        eclk = 1'b1;
        @(posedge clk);
        #1;
        eclk = 1'b0;
        rd_reg("eclk_count", LO0, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        eclk  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        eclk  = 1'b0;
        rd_reg("rst_prio_icr", ICR, 8'h00);
        rd_reg("rst_prio_lo", LO0, 8'hFF);
        rd_reg("rst_prio_cr", CR0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
